// File: rtl/hms_pkg.sv
// Shared encodings and constants for the hour/minute/second counter.
// Also provides the decimal-point mask helper used by the top level.
package hms_pkg;

  typedef enum logic {
    CLOCK = 1'b0,
    SET   = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SEC  = 2'd0,
    MIN  = 2'd1,
    HOUR = 2'd2
  } pos_e;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // Marks the two digits of the field being edited; dark while counting.
  function automatic logic [5:0] dp_mask(input state_e st, input pos_e p);
    logic [5:0] m;
    m = 6'b000000;
    if (st == SET) begin
      case (p)
        SEC:     m = 6'b000011;
        MIN:     m = 6'b001100;
        HOUR:    m = 6'b110000;
        default: m = 6'b000000;
      endcase
    end else begin
      m = 6'b000000;
    end
    return m;
  endfunction

endpackage

// File: rtl/hms_cnt_if.sv
// Tick/switch inputs and time/display outputs of the hms counter.
interface hms_cnt_if;
  import hms_pkg::*;

  logic       i_tick;
  logic       i_sw_mode;
  logic       i_sw_pos;
  logic       i_sw_inc;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_set_mode;
  logic [5:0] o_six_dp;

  modport master (
    output i_tick, i_sw_mode, i_sw_pos, i_sw_inc,
    input  o_sec, o_min, o_hour, o_set_mode, o_six_dp
  );

  modport slave (
    input  i_tick, i_sw_mode, i_sw_pos, i_sw_inc,
    output o_sec, o_min, o_hour, o_set_mode, o_six_dp
  );
endinterface

// File: rtl/hms_cnt_sw_edge.sv
// Rising-edge detector for a debounced switch level. Reset loads the
// live level so a switch held through reset release yields no edge.
module sw_edge (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic rise_s
);

  logic sw_d_r;

  // Delayed copy of the switch level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_d_r <= sw;
    end else begin
      sw_d_r <= sw;
    end
  end

  assign rise_s = sw & ~sw_d_r;

endmodule

// File: rtl/hms_cnt.sv
// Hour/minute/second timekeeper with button-driven SET editing.
// All outputs are registered; carries resolve on a single clock edge.
module hms_cnt
  import hms_pkg::*;
#(
  parameter int HOUR_MAX = 24
) (
  input logic      clk,
  input logic      rst,
  hms_cnt_if.slave bus
);

  localparam logic [4:0] HOUR_TOP = 5'(HOUR_MAX - 1);

  logic mode_e_s, pos_e_s, inc_e_s;

  sw_edge u_mode (.clk(clk), .rst(rst), .sw(bus.i_sw_mode), .rise_s(mode_e_s));
  sw_edge u_pos  (.clk(clk), .rst(rst), .sw(bus.i_sw_pos),  .rise_s(pos_e_s));
  sw_edge u_inc  (.clk(clk), .rst(rst), .sw(bus.i_sw_inc),  .rise_s(inc_e_s));

  state_e     state_r, state_s;
  pos_e       pos_r, pos_s;
  logic [5:0] sec_r, sec_s;
  logic [5:0] min_r, min_s;
  logic [4:0] hour_r, hour_s;
  logic       set_mode_r, set_mode_s;
  logic [5:0] dp_r, dp_s;

  // State, position, time fields and registered display flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= CLOCK;
      pos_r      <= SEC;
      sec_r      <= 6'd0;
      min_r      <= 6'd0;
      hour_r     <= 5'd0;
      set_mode_r <= 1'b0;
      dp_r       <= 6'd0;
    end else begin
      state_r    <= state_s;
      pos_r      <= pos_s;
      sec_r      <= sec_s;
      min_r      <= min_s;
      hour_r     <= hour_s;
      set_mode_r <= set_mode_s;
      dp_r       <= dp_s;
    end
  end

  // Next state and edit position; a mode edge overrides pos/inc.
  always_comb begin
    state_s = state_r;
    pos_s   = pos_r;
    if (mode_e_s) begin
      state_s = (state_r == CLOCK) ? SET : CLOCK;
      pos_s   = SEC;
    end else if ((state_r == SET) && pos_e_s) begin
      case (pos_r)
        SEC:     pos_s = MIN;
        MIN:     pos_s = HOUR;
        HOUR:    pos_s = SEC;
        default: pos_s = SEC;
      endcase
    end else begin
      pos_s = pos_r;
    end
  end

  // Time fields: cascaded carry while counting, isolated wrap while editing.
  always_comb begin
    sec_s  = sec_r;
    min_s  = min_r;
    hour_s = hour_r;
    if (state_r == CLOCK) begin
      if (bus.i_tick) begin
        if (sec_r == SEC_MAX) begin
          sec_s = 6'd0;
          if (min_r == MIN_MAX) begin
            min_s  = 6'd0;
            hour_s = (hour_r == HOUR_TOP) ? 5'd0 : hour_r + 5'd1;
          end else begin
            min_s = min_r + 6'd1;
          end
        end else begin
          sec_s = sec_r + 6'd1;
        end
      end else begin
        sec_s = sec_r;
      end
    end else if (inc_e_s && !mode_e_s && !pos_e_s) begin
      case (pos_r)
        SEC:     sec_s  = (sec_r == SEC_MAX) ? 6'd0 : sec_r + 6'd1;
        MIN:     min_s  = (min_r == MIN_MAX) ? 6'd0 : min_r + 6'd1;
        HOUR:    hour_s = (hour_r == HOUR_TOP) ? 5'd0 : hour_r + 5'd1;
        default: sec_s  = sec_r;
      endcase
    end else begin
      sec_s = sec_r;
    end
  end

  // Display flags derived from the upcoming state so they register in step.
  always_comb begin
    set_mode_s = (state_s == SET);
    dp_s       = dp_mask(state_s, pos_s);
  end

  assign bus.o_sec      = sec_r;
  assign bus.o_min      = min_r;
  assign bus.o_hour     = hour_r;
  assign bus.o_set_mode = set_mode_r;
  assign bus.o_six_dp   = dp_r;

endmodule
